// File: rtl/prbs_err_acc.sv
`default_nettype none
// ============================================================================
// Module   : prbs_err_acc
// Purpose  : Consumes the per-word VALID/MATCH results of the 48-bit PRBS
//            checker in the REC_CLK domain. It acquires lock on the stream
//            through a lock/loss hysteresis FSM. While locked it keeps
//            saturating word and error counts and a lock-loss count. It also
//            provides an atomic (optionally read-and-clear) snapshot.
// Ports    : REC_CLK, RST (async, active-high)
//            CE3, VALID, MATCH   - checker result qualifiers; sample = CE3&VALID
//            CLR                 - synchronous clear of counters and state
//            SNAP                - snapshot request pulse
//            LOCKED, ERR_FREE    - lock status
//            WORD_CNT, ERR_CNT   - saturating counters (CNT_W bits)
//            LOSS_CNT            - saturating lock-loss count (8 bits)
//            SNAP_WORDS/ERRS     - captured counters; SNAP_VLD one-cycle strobe
// Revision : 1.0 - initial release
// ============================================================================
module prbs_err_acc #(
    parameter int CNT_W     = 32,
    parameter int LOCK_GOOD = 16,
    parameter int LOSS_BAD  = 8
) (
    input  logic             REC_CLK,
    input  logic             RST,
    input  logic             CE3,
    input  logic             VALID,
    input  logic             MATCH,
    input  logic             CLR,
    input  logic             SNAP,
    output logic             LOCKED,
    output logic [CNT_W-1:0] WORD_CNT,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [7:0]       LOSS_CNT,
    output logic             ERR_FREE,
    output logic [CNT_W-1:0] SNAP_WORDS,
    output logic [CNT_W-1:0] SNAP_ERRS,
    output logic             SNAP_VLD
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0]       C_LOCK_GOOD = 8'(LOCK_GOOD);
    localparam logic [7:0]       C_LOSS_BAD  = 8'(LOSS_BAD);
    localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

    state_t           r_state;
    state_t           w_state;
    logic [7:0]       r_good;
    logic [7:0]       w_good;
    logic [7:0]       r_bad;
    logic [7:0]       w_bad;
    logic [CNT_W-1:0] w_words;
    logic [CNT_W-1:0] w_errs;
    logic [7:0]       w_loss;
    logic             w_err_free;
    logic             w_sample;
    logic [7:0]       w_good_inc;

    assign w_sample = CE3 & VALID;

    // The good-run counter is always zero while idle, so the first match
    // counts as run length one. This also covers LOCK_GOOD == 1, where that
    // first match locks directly.
    assign w_good_inc = (r_state == ST_IDLE) ? 8'd1 : r_good + 8'd1;

    always_comb begin
        w_state    = r_state;
        w_good     = r_good;
        w_bad      = r_bad;
        w_words    = WORD_CNT;
        w_errs     = ERR_CNT;
        w_loss     = LOSS_CNT;
        w_err_free = ERR_FREE;

        if (CLR) begin
            // A sample arriving in the same cycle as CLR is discarded.
            w_state    = ST_IDLE;
            w_good     = 8'd0;
            w_bad      = 8'd0;
            w_words    = '0;
            w_errs     = '0;
            w_loss     = 8'd0;
            w_err_free = 1'b0;
        end else if (w_sample) begin
            case (r_state)
                ST_IDLE, ST_ACQ: begin
                    if (MATCH) begin
                        if (w_good_inc == C_LOCK_GOOD) begin
                            // The lock-completing sample is not counted.
                            w_state    = ST_LOCKED;
                            w_good     = 8'd0;
                            w_bad      = 8'd0;
                            w_err_free = 1'b1;
                        end else begin
                            w_state = ST_ACQ;
                            w_good  = w_good_inc;
                        end
                    end else begin
                        w_state = ST_IDLE;
                        w_good  = 8'd0;
                    end
                end
                ST_LOCKED: begin
                    if (WORD_CNT != C_CNT_MAX) begin
                        w_words = WORD_CNT + C_CNT_ONE;
                    end
                    if (MATCH) begin
                        w_bad = 8'd0;
                    end else begin
                        w_err_free = 1'b0;
                        if (ERR_CNT != C_CNT_MAX) begin
                            w_errs = ERR_CNT + C_CNT_ONE;
                        end
                        if (r_bad + 8'd1 == C_LOSS_BAD) begin
                            // The triggering mismatch is still counted above.
                            w_state = ST_IDLE;
                            w_good  = 8'd0;
                            w_bad   = 8'd0;
                            if (LOSS_CNT != 8'hFF) begin
                                w_loss = LOSS_CNT + 8'd1;
                            end
                        end else begin
                            w_bad = r_bad + 8'd1;
                        end
                    end
                end
                default: begin
                    w_state = ST_IDLE;
                    w_good  = 8'd0;
                    w_bad   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge REC_CLK or posedge RST) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_good     <= 8'd0;
            r_bad      <= 8'd0;
            LOCKED     <= 1'b0;
            WORD_CNT   <= '0;
            ERR_CNT    <= '0;
            LOSS_CNT   <= 8'd0;
            ERR_FREE   <= 1'b0;
            SNAP_WORDS <= '0;
            SNAP_ERRS  <= '0;
            SNAP_VLD   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_good   <= w_good;
            r_bad    <= w_bad;
            LOCKED   <= (w_state == ST_LOCKED);
            WORD_CNT <= w_words;
            ERR_CNT  <= w_errs;
            LOSS_CNT <= w_loss;
            ERR_FREE <= w_err_free;
            SNAP_VLD <= SNAP;
            // Captures the pre-update counters, so a same-edge sample or
            // CLR is not reflected in the snapshot (read-and-clear).
            if (SNAP) begin
                SNAP_WORDS <= WORD_CNT;
                SNAP_ERRS  <= ERR_CNT;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/prbs_err_acc.md
Name: prbs_err_acc

Overview:
- Downstream consumer of the 48-bit PRBS word checker's per-word VALID/MATCH results, in the REC_CLK domain.
- Qualifies each checked word and acquires lock on the PRBS stream using a lock/loss hysteresis state machine.
- While locked, accumulates saturating word and error counts and counts lock-loss events.
- Provides an atomic snapshot (optionally read-and-clear) for the slow-control/readout side.

Parameters:
- CNT_W, 32: width of word and error counters.
- LOCK_GOOD, 16: consecutive matching samples needed to declare lock (1..255).
- LOSS_BAD, 8: consecutive mismatching samples while locked that declare loss of lock (1..255).

Ports:
- REC_CLK  input  1  receive clock (160 MHz).
- RST  input  1  asynchronous, active-high reset.
- CE3  input  1  word-rate clock enable, same phase that updates the checker's VALID/MATCH.
- VALID  input  1  checker result is valid.
- MATCH  input  1  checker word matched expected PRBS.
- CLR  input  1  synchronous clear of counters and state.
- SNAP  input  1  snapshot request, single-cycle pulse.
- LOCKED  output  1  state == LOCKED.
- WORD_CNT  output  CNT_W  words checked while locked.
- ERR_CNT  output  CNT_W  mismatched words while locked.
- LOSS_CNT  output  8  lock-loss events.
- ERR_FREE  output  1  locked, with no error since the most recent lock.
- SNAP_WORDS  output  CNT_W  captured WORD_CNT.
- SNAP_ERRS  output  CNT_W  captured ERR_CNT.
- SNAP_VLD  output  1  one-cycle strobe: snapshot registers updated.

Behaviour:
- Sample event: S = CE3 & VALID. Nothing changes on cycles without S, except CLR and SNAP handling.
- All outputs registered. Reset values: every output 0; state IDLE; run counters 0.
- State machine, evaluated on S:
  - IDLE:
    - MATCH=1: go to ACQ, good_run=1.
    - MATCH=0: stay in IDLE.
    - If LOCK_GOOD==1, a match goes directly to LOCKED.
  - ACQ:
    - MATCH=1: good_run++. When good_run reaches LOCK_GOOD, go to LOCKED, clear bad_run, set ERR_FREE=1.
    - MATCH=0: good_run=0 and go to IDLE.
  - LOCKED:
    - Every sample: WORD_CNT++.
    - MATCH=0: ERR_CNT++, bad_run++, ERR_FREE=0.
    - MATCH=1: bad_run=0.
    - When bad_run reaches LOSS_BAD: go to IDLE, LOSS_CNT++, good_run=0. The mismatching sample that triggers the loss is still counted in WORD_CNT and ERR_CNT.
- The sample that completes lock is not counted. Counting starts with the next sample.
- VALID low while LOCKED: state and counters hold. Gaps in VALID do not break lock or runs.
- Counter saturation:
  - WORD_CNT and ERR_CNT saturate at all-ones, independently; no wrap.
  - LOSS_CNT saturates at 255.
- Latency: a sample seen at edge N updates state and counters visible after edge N. LOCKED rises on the edge that consumes the LOCK_GOOD-th match.
- CLR (synchronous, any cycle): zero WORD_CNT, ERR_CNT, LOSS_CNT and run counters; state to IDLE; ERR_FREE=0. CLR has priority over a same-cycle S, which is discarded. Snapshot registers are not cleared by CLR.
- SNAP: on the edge where SNAP=1, SNAP_WORDS and SNAP_ERRS take the counter register values before any same-edge update. SNAP_VLD=1 in the following cycle only.
- SNAP together with CLR: snapshot captures pre-clear values, then counters clear (read-and-clear). SNAP together with S: snapshot excludes that sample.
- Back-to-back SNAP: each captures and strobes; SNAP_VLD may remain high consecutively.
- Asynchronous RST mid-operation: immediate return to reset values, including snapshot registers.

Test Plan:
- Reset, then 16 samples MATCH=1 -> LOCKED=1 after the 16th; WORD_CNT=0, ERR_FREE=1. Then 10 matches -> WORD_CNT=10, ERR_CNT=0.
- In ACQ, 10 matches, 1 mismatch, then 16 matches -> LOCKED only after the final 16th match; LOSS_CNT=0.
- Locked: pattern of 7 mismatches, 1 match, 8 mismatches -> lock lost on the 16th sample; ERR_CNT=15, WORD_CNT=16, LOSS_CNT=1, LOCKED=0, ERR_FREE=0.
- Locked, VALID toggling and CE3 gaps over 100 cycles containing 20 true samples (3 mismatches) -> WORD_CNT=20, ERR_CNT=3, LOCKED=1.
- Locked with WORD_CNT=1234: SNAP+CLR in the same cycle as a sample -> SNAP_WORDS=1234, SNAP_VLD high for 1 cycle, WORD_CNT=0, state IDLE.
- CNT_W=4 build: 20 locked samples, all mismatching, with LOSS_BAD=255 -> WORD_CNT=ERR_CNT=15 (saturated). Assert RST mid-run -> all outputs 0 immediately.
